// File: rtl/div3_shift_sub_if.sv
// Start/done handshake and operand/result bus for the exact divide-by-3 unit.
// The master drives the request; the slave (the divider) returns the results.
interface div3_shift_sub_if #(
  parameter int IN_WIDTH = 1028,
  parameter int LIMB     = 32
);
  logic                start;
  logic [IN_WIDTH-1:0] in_a;
  logic                busy;
  logic                done;
  logic [IN_WIDTH-1:0] out_q;
  logic [1:0]          out_r;
  logic                check_err;

  modport master (
    output start, in_a,
    input  busy, done, out_q, out_r, check_err
  );

  modport slave (
    input  start, in_a,
    output busy, done, out_q, out_r, check_err
  );
endinterface

// File: rtl/div3_shift_sub.sv
// Multi-cycle exact divide-by-3: long division, one LIMB-bit digit per cycle, MSB limb first.
// Optional build macro DIV3_SELF_CHECK_EN adds an operand copy and a 3*q+r reconstruction compare.
module div3_shift_sub #(
  parameter int IN_WIDTH = 1028,
  parameter int LIMB     = 32
) (
  input  logic             clk,
  input  logic             reset,
  div3_shift_sub_if.slave  bus
);
  localparam int NLIMB = (IN_WIDTH + LIMB - 1) / LIMB;
  localparam int FULLW = NLIMB * LIMB;
  localparam int CW    = $clog2(NLIMB + 1);
  localparam logic [CW-1:0]   LAST  = CW'(NLIMB - 1);
  localparam logic [LIMB+1:0] THREE = (LIMB+2)'(3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [FULLW-1:0]    shreg_q;
  logic [IN_WIDTH-1:0] q_q;
  logic [1:0]          rem_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [IN_WIDTH-1:0] out_q_q;
  logic [1:0]          out_r_q;

  logic [LIMB+1:0]     v;
  logic [LIMB-1:0]     digit;
  logic [1:0]          rem_d;
  logic [IN_WIDTH-1:0] q_d;

  // v < 3*2^LIMB because rem <= 2, so the digit always fits in LIMB bits.
  always_comb begin
    v     = {rem_q, shreg_q[FULLW-1 -: LIMB]};
    digit = LIMB'(v / THREE);
    rem_d = 2'(v % THREE);
    q_d   = IN_WIDTH'({q_q, digit});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q_q <= '0;
      out_r_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            shreg_q <= FULLW'(bus.in_a);
            q_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          shreg_q <= shreg_q << LIMB;
          q_q     <= q_d;
          rem_q   <= rem_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q_q <= q_d;
            out_r_q <= rem_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out_q = out_q_q;
  assign bus.out_r = out_r_q;

`ifdef DIV3_SELF_CHECK_EN
  logic [IN_WIDTH-1:0] op_q;
  logic [IN_WIDTH+1:0] recon;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
    end else if ((state_q != S_RUN) && bus.start) begin
      op_q <= bus.in_a;
    end
  end

  always_comb begin
    recon = ({2'b00, out_q_q} << 1) + {2'b00, out_q_q} + (IN_WIDTH+2)'(out_r_q);
  end

  assign bus.check_err = done_q && (recon != {2'b00, op_q});

  always @(posedge clk) begin
    if (!reset) begin
      assert (!bus.check_err) else $error("div3_shift_sub: 3*q+r does not reconstruct the operand");
    end
  end
`else
  assign bus.check_err = 1'b0;
`endif
endmodule

// File: doc/div3_shift_sub.md
Name: div3_shift_sub

Overview:
- Multi-cycle exact divide-by-3 unit: takes a wide operand (typically the 3·A multiple produced by the shift/add multiple generator) and returns quotient and remainder, recovering A.
- Inverse direction of the 1x/2x/3x multiple generator; used to cross-check the multiple table and to decompose 3·A values in the Montgomery datapath.
- Radix-2^LIMB long division, MSB limb first, one limb per cycle; same start/done handshake as the adder/shifter blocks.

Parameters:
- IN_WIDTH, 1028, operand and quotient width in bits.
- LIMB, 32, bits consumed per cycle; NLIMB = ceil(IN_WIDTH/LIMB) (33 at defaults); operand zero-padded at MSB to NLIMB·LIMB.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when idle or done.
- in_a  in  IN_WIDTH  dividend; sampled on the accepted start edge only.
- busy  out  1  high while RUN.
- done  out  1  one-cycle pulse; results valid.
- out_q  out  IN_WIDTH  quotient floor(in_a/3).
- out_r  out  2  remainder in_a mod 3 (0..2).
- check_err  out  1  self-check flag (see Optional Feature).

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, out_q=0, out_r=0, check_err=0, counter=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 -> load padded in_a into shift reg, rem=0, q=0, cnt=0; go RUN.
- RUN, each edge: v = {rem, top LIMB bits of shift reg} (LIMB+2 bits, v < 3·2^LIMB); digit = v/3 (fits LIMB bits); rem = v mod 3; q = {q, digit} shifted left by LIMB; shift reg shifted left by LIMB; cnt++. After NLIMB RUN edges -> DONE.
- Division by 3 in RUN is combinational, constant divisor; no general divider.
- DONE (one cycle): done=1, busy=0; out_q = low IN_WIDTH bits of q; out_r = rem.
- From DONE, next edge: go IDLE. If start=1 in the DONE cycle, accept it instead: new operand loaded, go RUN directly (back-to-back, no bubble).
- Latency: done high in the cycle after edge E0+NLIMB (NLIMB+1 cycles from start cycle to done cycle; 34 at defaults).
- out_q/out_r hold their value after done until the next DONE or reset.
- start while RUN: ignored, no effect on operand or counter.
- in_a changes after the accepted start edge: no effect.
- Reset asserted mid-RUN: abort immediately; no done pulse; outputs zero.
- Quotient bits above IN_WIDTH from padding are always 0 and are discarded.

Optional Feature:
- Macro DIV3_SELF_CHECK_EN.
- Defined: operand copy held in a register; in the DONE cycle check_err = (3·out_q + out_r != operand), a combinational compare valid only while done=1; a simulation $error is raised on mismatch.
- Undefined: no copy register, no compare; check_err tied 0. Port list is identical in both builds.

Test Plan:
- in_a = 3·A, where A = the standard 1024-bit test vector 0x993a45a7…45d8c3 zero-extended to 1028 bits -> out_q = A, out_r = 0, done exactly 34 cycles after the start cycle, busy high for 33 cycles.
- in_a = 0 -> out_q = 0, out_r = 0. in_a = 5 -> out_q = 1, out_r = 2. in_a = 7 -> out_q = 2, out_r = 1.
- in_a = 2^1028-1 -> out_q = (2^1028-1)/3 (all 0x5… pattern), out_r = 0; check_err = 0 with DIV3_SELF_CHECK_EN.
- start pulsed again at cycle 10 of RUN with a different in_a -> ignored; result still that of the first operand; single done pulse.
- reset at cycle 15 of RUN -> busy=0, done never pulses, outputs 0; next start with in_a = 9 -> out_q = 3, out_r = 0.
- start held in the DONE cycle with in_a = 6 -> no IDLE bubble; second done 34 cycles later with out_q = 2, out_r = 0.
